// File: rtl/median_pkg.sv
// Shared types and sizing helpers for the streaming median engine.
package median_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMP,
        OUT
    } state_t;

    function automatic int comp_cycles(input int number);
        return number * (number + 1) / 2;
    endfunction

    // Bits needed to hold a counter that runs 0 .. count-1.
    function automatic int cnt_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/mce_w.sv
// Combinational compare-exchange unit: unsigned max/min of two samples.
module mce_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o
);

    assign max_o = (a_i >= b_i) ? a_i : b_i;
    assign min_o = (a_i >= b_i) ? b_i : a_i;

endmodule

// File: rtl/median_stream.sv
// Streaming median engine: loads NUMBER samples, extracts the median over a fixed-latency
// ring of max-extraction passes. Optional MED_BYPASS_EN adds a centre-sample bypass input.
module median_stream
    import median_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUMBER = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] di_i,
    input  logic             dsi_i,
    output logic             drdy_o,
    output logic [WIDTH-1:0] do_o,
    output logic             dov_o,
    input  logic             dor_i
`ifdef MED_BYPASS_EN
    ,
    input  logic             byp_i
`endif
);

    localparam int COMP_N = comp_cycles(NUMBER);
    localparam int CW     = cnt_width(COMP_N);
    localparam int LW     = cnt_width(NUMBER);

    localparam logic [CW-1:0] COMP_LAST = CW'(COMP_N - 1);
    localparam logic [LW-1:0] RING_LAST = LW'(NUMBER - 1);
    localparam logic [LW-1:0] CENTRE    = LW'((NUMBER - 1) / 2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ring_q [NUMBER];
    logic [WIDTH-1:0] ring_d [NUMBER];
    logic [LW-1:0]    loadCnt_q, loadCnt_d;
    logic [CW-1:0]    compCnt_q, compCnt_d;
    logic [LW-1:0]    passCyc_q, passCyc_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] do_q, do_d;
    logic [WIDTH-1:0] carry, cmpMax, cmpMin;
`ifdef MED_BYPASS_EN
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] centre_q, centre_d;
`endif

    // Each pass starts from the minimum value, so the slot vacated by the extracted
    // maximum is refilled with a value that can never win a later pass.
    assign carry = (passCyc_q == '0) ? '0 : max_q;

    mce_w #(.WIDTH(WIDTH)) u_mce (
        .a_i  (ring_q[0]),
        .b_i  (carry),
        .max_o(cmpMax),
        .min_o(cmpMin)
    );

    always_comb begin
        state_d   = state_q;
        ring_d    = ring_q;
        loadCnt_d = loadCnt_q;
        compCnt_d = compCnt_q;
        passCyc_d = passCyc_q;
        max_d     = max_q;
        do_d      = do_q;
        drdy_o    = 1'b0;
`ifdef MED_BYPASS_EN
        byp_d     = byp_q;
        centre_d  = centre_q;
`endif
        case (state_q)
            LOAD: begin
                drdy_o = 1'b1;
                if (dsi_i) begin
                    for (int i = 0; i < NUMBER - 1; i++) ring_d[i] = ring_q[i+1];
                    ring_d[NUMBER-1] = di_i;
`ifdef MED_BYPASS_EN
                    if (loadCnt_q == '0) byp_d = byp_i;
                    if (loadCnt_q == CENTRE) centre_d = di_i;
`endif
                    if (loadCnt_q == RING_LAST) begin
                        loadCnt_d = '0;
                        compCnt_d = '0;
                        passCyc_d = '0;
                        state_d   = COMP;
                    end else begin
                        loadCnt_d = loadCnt_q + LW'(1);
                    end
                end
            end
            COMP: begin
                for (int i = 0; i < NUMBER - 1; i++) ring_d[i] = ring_q[i+1];
                ring_d[NUMBER-1] = cmpMin;
                max_d     = cmpMax;
                passCyc_d = (passCyc_q == RING_LAST) ? '0 : passCyc_q + LW'(1);
                if (compCnt_q == COMP_LAST) begin
`ifdef MED_BYPASS_EN
                    do_d = byp_q ? centre_q : cmpMax;
`else
                    do_d = cmpMax;
`endif
                    compCnt_d = '0;
                    state_d   = OUT;
                end else begin
                    compCnt_d = compCnt_q + CW'(1);
                end
            end
            OUT: begin
                if (dor_i) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LOAD;
            for (int i = 0; i < NUMBER; i++) ring_q[i] <= '0;
            loadCnt_q <= '0;
            compCnt_q <= '0;
            passCyc_q <= '0;
            max_q     <= '0;
            do_q      <= '0;
`ifdef MED_BYPASS_EN
            byp_q     <= 1'b0;
            centre_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            loadCnt_q <= loadCnt_d;
            compCnt_q <= compCnt_d;
            passCyc_q <= passCyc_d;
            max_q     <= max_d;
            do_q      <= do_d;
`ifdef MED_BYPASS_EN
            byp_q     <= byp_d;
            centre_q  <= centre_d;
`endif
        end
    end

    assign dov_o = (state_q == OUT);
    assign do_o  = do_q;

endmodule

// File: tb/tb_median_stream.sv
// Randomised and directed bench for median_stream against a sort-based reference model.
module tb_median_stream;

    localparam int W   = 8;
    localparam int NUM = 9;
    localparam int LAT = NUM * (NUM + 1) / 2;

    typedef logic [W-1:0] win_t [NUM];

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] di;
    logic         dsi;
    logic         drdy;
    logic [W-1:0] dout;
    logic         dov;
    logic         dor;
    logic         byp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    median_stream #(.WIDTH(W), .NUMBER(NUM)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .di_i  (di),
        .dsi_i (dsi),
        .drdy_o(drdy),
        .do_o  (dout),
        .dov_o (dov),
        .dor_i (dor)
`ifdef MED_BYPASS_EN
        ,
        .byp_i (byp)
`endif
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: sort the window and take the lower-middle rank, or the centre sample.
    function automatic int refResult(input win_t s, input logic bypSel);
        int q[$];
        if (bypSel) return int'(s[(NUM-1)/2]);
        for (int i = 0; i < NUM; i++) q.push_back(int'(s[i]));
        q.sort();
        return q[(NUM-1)/2];
    endfunction

    task automatic applyStimulus(input win_t s, input int gapAt, input int gapLen,
                                 input logic bypVal, input bit randGaps);
        for (int i = 0; i < NUM; i++) begin
            if (i == gapAt) begin
                dsi = 1'b0;
                repeat (gapLen) begin
                    @(posedge clk); #1;
                end
            end
            if (randGaps) begin
                dsi = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            di  = s[i];
            dsi = 1'b1;
            byp = (i == 0) ? bypVal : ~bypVal;
            @(negedge clk);
            checkOutput("drdy_load", int'(drdy), 1);
            @(posedge clk); #1;
        end
        dsi = 1'b0;
        di  = '0;
    endtask

    task automatic awaitResult(input string tag, input int expVal, input int stall);
        int lat = 0;
        bit found = 0;
        dor = (stall == 0);
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (!found && !dov) checkOutput({tag, "_drdy_comp"}, int'(drdy), 0);
            if (dov) begin
                lat = k;
                found = 1;
                break;
            end
        end
        checkOutput({tag, "_dov_seen"}, int'(found), 1);
        checkOutput({tag, "_latency"}, lat, LAT);
        checkOutput({tag, "_do"}, int'(dout), expVal);
        checkOutput({tag, "_drdy_out"}, int'(drdy), 0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_stall_dov"}, int'(dov), 1);
            checkOutput({tag, "_stall_do"}, int'(dout), expVal);
            checkOutput({tag, "_stall_drdy"}, int'(drdy), 0);
        end
        dor = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "_dov_drop"}, int'(dov), 0);
        checkOutput({tag, "_drdy_back"}, int'(drdy), 1);
    endtask

    task automatic runWindow(input string tag, input win_t s, input int gapAt, input int gapLen,
                             input logic bypVal, input bit randGaps, input int stall);
        int exp;
`ifdef MED_BYPASS_EN
        exp = refResult(s, bypVal);
`else
        exp = refResult(s, 1'b0);
`endif
        applyStimulus(s, gapAt, gapLen, bypVal, randGaps);
        awaitResult(tag, exp, stall);
    endtask

    initial begin
        win_t s;
        bit seen;

        rst = 1'b1;
        di  = '0;
        dsi = 1'b0;
        dor = 1'b1;
        byp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_do", int'(dout), 0);
        checkOutput("reset_dov", int'(dov), 0);
        checkOutput("reset_drdy", int'(drdy), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NUM; i++) s[i] = W'(i + 1);
        runWindow("ascending", s, -1, 0, 1'b0, 0, 0);

        for (int i = 0; i < NUM; i++) s[i] = W'(NUM - i);
        runWindow("descending_gap", s, 4, 3, 1'b0, 0, 0);

        for (int i = 0; i < NUM; i++) s[i] = W'((i % 3 == 0) ? 3 : (i % 3 == 1) ? 0 : 7);
        runWindow("ties", s, -1, 0, 1'b0, 0, 0);

        for (int i = 0; i < NUM; i++) s[i] = 8'hFF;
        runWindow("all_max", s, -1, 0, 1'b0, 0, 0);

        for (int i = 0; i < NUM; i++) s[i] = 8'h00;
        runWindow("all_zero", s, -1, 0, 1'b0, 0, 0);

        for (int i = 0; i < NUM; i++) s[i] = W'($urandom_range(0, 255));
        runWindow("stall", s, -1, 0, 1'b0, 0, 20);

        for (int i = 0; i < NUM; i++) s[i] = W'($urandom_range(0, 255));
        runWindow("after_stall", s, -1, 0, 1'b0, 0, 0);

        // Abort a window ten cycles into the compute phase.
        for (int i = 0; i < NUM; i++) s[i] = W'(200 + i);
        applyStimulus(s, -1, 0, 1'b0, 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_dov", int'(dov), 0);
        checkOutput("abort_do", int'(dout), 0);
        checkOutput("abort_drdy", int'(drdy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (dov) seen = 1;
        end
        checkOutput("abort_no_dov", int'(seen), 0);

        for (int i = 0; i < NUM; i++) s[i] = W'(10 * (i + 1));
        runWindow("post_abort", s, -1, 0, 1'b0, 0, 0);

        for (int w = 0; w < 10; w++) begin
            int hi;
            hi = ($urandom_range(0, 1) == 0) ? 3 : 255;
            for (int i = 0; i < NUM; i++) s[i] = W'($urandom_range(0, hi));
            runWindow($sformatf("rand%0d", w), s, -1, 0, 1'b0, 1, $urandom_range(0, 3));
        end

`ifdef MED_BYPASS_EN
        s = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        runWindow("bypass_on", s, -1, 0, 1'b1, 0, 0);
        runWindow("bypass_off", s, -1, 0, 1'b0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
